clk_freq_monitor: RTL and testbench

- Downstream consumer of the 50 MHz to 3 MHz DCM output.
- Runs entirely in the 50 MHz reference domain. Treats the synthesized clock (clkmon) as an asynchronous data input.
- Counts clkmon rising edges over a fixed gate window of reference cycles and reports the count.
- Declares frequency lock after a run of consecutive in-range windows. Board-level logic uses locked to hold off the 3 MHz consumers.

---
 rtl/clk_freq_monitor.sv | 151 +++++++++++++++
 tb/tb_clk_freq_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Measures the frequency of an asynchronous clock (clkmon) by counting its rising
// edges over a fixed window of reference cycles, and tracks frequency lock.
module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 50000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 3100,
  parameter int EXP_MAX      = 3150,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkmon,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             locked
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  EXP_LO    = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]  EXP_HI    = CNT_W'(EXP_MAX);
  localparam logic [3:0]        LOCK_N    = 4'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (edge-detect delay)
  logic [2:0]        sync_q, sync_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        good_q, good_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              count_valid_q, count_valid_d;
  logic              in_range_q, in_range_d;
  logic              overflow_q, overflow_d;
  logic              locked_q, locked_d;

  logic              edge_det, tc, sat_now, ovf_next, win_in_range;
  logic [CNT_W-1:0]  cnt_next;

  // Datapath: window counters and the result latched on the terminal cycle.
  always_comb begin
    sync_d       = {sync_q[1:0], clkmon};
    edge_det     = sync_q[1] & ~sync_q[2];
    tc           = (gate_q == GATE_LAST);
    sat_now      = edge_det && (edge_cnt_q == CNT_MAX);
    cnt_next     = (edge_det && !sat_now) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    ovf_next     = ovf_q | sat_now;
    win_in_range = !ovf_next && (cnt_next >= EXP_LO) && (cnt_next <= EXP_HI);

    gate_d        = tc ? '0 : gate_q + 1'b1;
    edge_cnt_d    = tc ? '0 : cnt_next;
    ovf_d         = tc ? 1'b0 : ovf_next;
    count_d       = tc ? cnt_next : count_q;
    overflow_d    = tc ? ovf_next : overflow_q;
    in_range_d    = tc ? win_in_range : in_range_q;
    count_valid_d = tc;
  end

  // Lock FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock FSM: next state, advanced only at the end of each window.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (tc) begin
      case (state_q)
        UNLOCKED: begin
          if (win_in_range) begin
            good_d  = 4'd1;
            state_d = (LOCK_N == 4'd1) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (win_in_range) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            good_d  = '0;
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!win_in_range) begin
            good_d  = '0;
            state_d = UNLOCKED;
          end
        end
        default: begin
          good_d  = '0;
          state_d = UNLOCKED;
        end
      endcase
    end
  end

  // Lock FSM: output, registered so it moves with the count_valid strobe.
  always_comb begin
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      gate_q        <= '0;
      edge_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      overflow_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      ovf_q         <= ovf_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      overflow_q    <= overflow_d;
      locked_q      <= locked_d;
    end
  end

  // count_valid is a one-cycle strobe with no ready: consumers sample count,
  // in_range, overflow and locked while it is high; the values hold until the next strobe.
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign overflow    = overflow_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: windows of 100 reference cycles, expected window
// results queued as clkmon is reprogrammed and checked at each count_valid.
module tb_clk_freq_monitor;

  typedef struct packed {
    logic [3:0] cmin;
    logic [3:0] cmax;
    logic [2:0] flags;  // {in_range, overflow, locked}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkmon = 1'b0;
  logic [3:0] count;
  logic       count_valid, in_range, overflow, locked;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  int   mon_half  = 0;
  logic mon_level = 1'b0;
  int   mon_gen   = 0;
  int   mon_seen  = 0;
  int   mon_ph    = 0;

  clk_freq_monitor #(
    .GATE_CYCLES (100),
    .CNT_W       (4),
    .EXP_MIN     (5),
    .EXP_MAX     (7),
    .LOCK_WINDOWS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkmon     (clkmon),
    .count      (count),
    .count_valid(count_valid),
    .in_range   (in_range),
    .overflow   (overflow),
    .locked     (locked)
  );

  // clock / reset block
  always #10 clk = ~clk;

  // clkmon source: changes on falling clk edges; a restart forces it low (or to the stuck level)
  always @(negedge clk) begin
    if (mon_gen != mon_seen) begin
      mon_seen = mon_gen;
      mon_ph   = 0;
      clkmon   = (mon_half == 0) ? mon_level : 1'b0;
    end else if (mon_half != 0) begin
      mon_ph = mon_ph + 1;
      if (mon_ph == mon_half) begin
        mon_ph = 0;
        clkmon = ~clkmon;
      end
    end
  end

  function automatic exp_t mk(input int cmin, input int cmax, input logic [2:0] flags);
    exp_t e;
    e.cmin  = 4'(cmin);
    e.cmax  = 4'(cmax);
    e.flags = flags;
    return e;
  endfunction

  // driver tasks
  task automatic set_mon(input int half, input logic lvl);
    mon_half  = half;
    mon_level = lvl;
    mon_gen   = mon_gen + 1;
  endtask

  // Called just after a count_valid sample; reprograms clkmon 2 cycles before the
  // window ends so the next window sees only the new waveform.
  task automatic drive_window(input int half, input exp_t nx, input bit do_push);
    repeat (98) @(posedge clk);
    #1;
    set_mon(half, 1'b0);
    if (do_push) exp_q.push_back(nx);
  endtask

  task automatic wait_cv(output int waited);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!count_valid && waited < 10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_mon(0, 1'($urandom_range(0, 1)));
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, expected 0", count);
    end
    n_tests++;
    if ({count_valid, in_range, overflow, locked} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got cv/ir/ov/lk=%b, expected 0000",
               {count_valid, in_range, overflow, locked});
    end
  endtask

  task automatic test_lock_acquire();
    int   half [3] = '{8, 8, 8};
    exp_t nx [3];
    exp_t e;
    int   waited;
    nx[0] = mk(6, 7, 3'b100);
    nx[1] = mk(6, 7, 3'b101);
    nx[2] = mk(6, 7, 3'b101);
    rst = 1'b0;
    set_mon(8, 1'b0);
    exp_q.push_back(mk(6, 7, 3'b100));
    for (int i = 0; i < 3; i++) begin
      drive_window(half[i], nx[i], 1'b1);
      wait_cv(waited);
      e = exp_q.pop_front();
      n_tests++;
      if (98 + waited != 100) begin
        n_fail++;
        $display("FAIL acquire_period w%0d: got %0d cycles, expected 100", i, 98 + waited);
      end
      n_tests++;
      if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
        n_fail++;
        $display("FAIL acquire_count w%0d: got %0d, expected %0d..%0d", i, count, e.cmin, e.cmax);
      end
      n_tests++;
      if ({in_range, overflow, locked} !== e.flags) begin
        n_fail++;
        $display("FAIL acquire_flags w%0d: got ir/ov/lk=%b, expected %b", i,
                 {in_range, overflow, locked}, e.flags);
      end
    end
  endtask

  task automatic test_lock_loss();
    int   half [2] = '{20, 8};
    exp_t nx [2];
    exp_t e;
    int   waited;
    nx[0] = mk(2, 3, 3'b000);
    nx[1] = mk(6, 7, 3'b100);
    for (int i = 0; i < 2; i++) begin
      drive_window(half[i], nx[i], 1'b1);
      wait_cv(waited);
      e = exp_q.pop_front();
      n_tests++;
      if (98 + waited != 100) begin
        n_fail++;
        $display("FAIL loss_period w%0d: got %0d cycles, expected 100", i, 98 + waited);
      end
      n_tests++;
      if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
        n_fail++;
        $display("FAIL loss_count w%0d: got %0d, expected %0d..%0d", i, count, e.cmin, e.cmax);
      end
      n_tests++;
      if ({in_range, overflow, locked} !== e.flags) begin
        n_fail++;
        $display("FAIL loss_flags w%0d: got ir/ov/lk=%b, expected %b", i,
                 {in_range, overflow, locked}, e.flags);
      end
    end
  endtask

  task automatic test_window_pattern();
    int   half [6] = '{8, 20, 8, 8, 8, 0};
    exp_t nx [6];
    exp_t e;
    int   waited;
    nx[0] = mk(6, 7, 3'b100);
    nx[1] = mk(2, 3, 3'b000);
    nx[2] = mk(6, 7, 3'b100);
    nx[3] = mk(6, 7, 3'b100);
    nx[4] = mk(6, 7, 3'b101);
    nx[5] = mk(0, 0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      drive_window(half[i], nx[i], 1'b1);
      wait_cv(waited);
      e = exp_q.pop_front();
      n_tests++;
      if (98 + waited != 100) begin
        n_fail++;
        $display("FAIL pattern_period w%0d: got %0d cycles, expected 100", i, 98 + waited);
      end
      n_tests++;
      if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
        n_fail++;
        $display("FAIL pattern_count w%0d: got %0d, expected %0d..%0d", i, count, e.cmin, e.cmax);
      end
      n_tests++;
      if ({in_range, overflow, locked} !== e.flags) begin
        n_fail++;
        $display("FAIL pattern_flags w%0d: got ir/ov/lk=%b, expected %b", i,
                 {in_range, overflow, locked}, e.flags);
      end
    end
  endtask

  task automatic test_stuck_low();
    exp_t e;
    int   waited;
    drive_window(1, mk(15, 15, 3'b010), 1'b1);
    wait_cv(waited);
    e = exp_q.pop_front();
    n_tests++;
    if (98 + waited != 100) begin
      n_fail++;
      $display("FAIL stuck_period: got %0d cycles, expected 100", 98 + waited);
    end
    n_tests++;
    if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
      n_fail++;
      $display("FAIL stuck_count: got %0d, expected %0d..%0d", count, e.cmin, e.cmax);
    end
    n_tests++;
    if ({in_range, overflow, locked} !== e.flags) begin
      n_fail++;
      $display("FAIL stuck_flags: got ir/ov/lk=%b, expected %b", {in_range, overflow, locked}, e.flags);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int   waited;
    drive_window(8, mk(6, 7, 3'b100), 1'b1);
    wait_cv(waited);
    e = exp_q.pop_front();
    n_tests++;
    if (98 + waited != 100) begin
      n_fail++;
      $display("FAIL ovf_period: got %0d cycles, expected 100", 98 + waited);
    end
    n_tests++;
    if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d, expected %0d..%0d", count, e.cmin, e.cmax);
    end
    n_tests++;
    if ({in_range, overflow, locked} !== e.flags) begin
      n_fail++;
      $display("FAIL ovf_flags: got ir/ov/lk=%b, expected %b", {in_range, overflow, locked}, e.flags);
    end
  endtask

  task automatic test_reset_mid();
    int   half [5] = '{8, 8, 8, 8, 8};
    bit   push [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t nx [5];
    exp_t e;
    int   waited;
    nx[0] = mk(6, 7, 3'b100);
    nx[1] = mk(0, 0, 3'b000);
    nx[2] = mk(6, 7, 3'b100);
    nx[3] = mk(6, 7, 3'b101);
    nx[4] = mk(0, 0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        // ACQUIRE with good=2 here; abort the window at gate count 60
        repeat (60) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (count !== 4'd0) begin
          n_fail++;
          $display("FAIL midrst_count: got %0d, expected 0", count);
        end
        n_tests++;
        if ({count_valid, in_range, overflow, locked} !== 4'b0000) begin
          n_fail++;
          $display("FAIL midrst_flags: got cv/ir/ov/lk=%b, expected 0000",
                   {count_valid, in_range, overflow, locked});
        end
        rst = 1'b0;
        set_mon(8, 1'b0);
        exp_q.push_back(mk(6, 7, 3'b100));
      end
      drive_window(half[i], nx[i], push[i]);
      wait_cv(waited);
      e = exp_q.pop_front();
      n_tests++;
      if (98 + waited != 100) begin
        n_fail++;
        $display("FAIL midrst_period w%0d: got %0d cycles, expected 100", i, 98 + waited);
      end
      n_tests++;
      if ($isunknown(count) || count < e.cmin || count > e.cmax) begin
        n_fail++;
        $display("FAIL midrst_count w%0d: got %0d, expected %0d..%0d", i, count, e.cmin, e.cmax);
      end
      n_tests++;
      if ({in_range, overflow, locked} !== e.flags) begin
        n_fail++;
        $display("FAIL midrst_flags w%0d: got ir/ov/lk=%b, expected %b", i,
                 {in_range, overflow, locked}, e.flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_window_pattern();
    test_stuck_low();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
